// File: rtl/pim_cmp_pkg.sv
// Shared types for the PIM bit-serial compare blocks: FSM states, result record, stats width.
package pim_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cmp_state_t;

  localparam int unsigned STAT_W = 16;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

endpackage

// File: rtl/lt_int_bitserial_if.sv
// Handshake bundle for the bit-serial comparator: start/beat input side and result output side.
interface lt_int_bitserial_if;
  logic start;
  logic signed_mode;
  logic in_valid;
  logic in_ready;
  logic a_bit;
  logic b_bit;
  logic out_valid;
  logic out_ready;
  logic lt;
  logic eq;
  logic gt;
  logic busy;

  modport master (
    output start, signed_mode, in_valid, a_bit, b_bit, out_ready,
    input  in_ready, out_valid, lt, eq, gt, busy
  );

  modport slave (
    input  start, signed_mode, in_valid, a_bit, b_bit, out_ready,
    output in_ready, out_valid, lt, eq, gt, busy
  );
endinterface

// File: rtl/bitserial_cmp_cell.sv
// One LSB-first compare step: folds a bit pair into the running lt/eq accumulators.
module bitserial_cmp_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  input  logic lt_acc,
  input  logic eq_acc,
  output logic lt_nxt,
  output logic eq_nxt
);

  always_comb begin
    lt_nxt = lt_acc;
    eq_nxt = eq_acc;
    if (a_bit != b_bit) begin
      // In two's complement the MSB carries negative weight, so a set A sign bit means A < B.
      lt_nxt = (is_msb && signed_mode) ? a_bit : b_bit;
      eq_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/lt_int_bitserial.sv
// Bit-serial signed/unsigned comparator: WIDTH LSB-first beats in, one lt/eq/gt result out.
// Optional saturating result counters when LT_INT_BITSERIAL_STATS_EN is defined.
module lt_int_bitserial
  import pim_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  lt_int_bitserial_if.slave   bus
`ifdef LT_INT_BITSERIAL_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_cnt,
  output logic [STAT_W-1:0]   stat_lt_cnt
`endif
);

  cmp_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             signed_q;
  logic             lt_acc_q;
  logic             eq_acc_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  cmp_res_t         res_q;

  logic is_msb;
  logic lt_nxt;
  logic eq_nxt;

  assign is_msb = (cnt_q == CNT_W'(WIDTH - 1));

  bitserial_cmp_cell u_cell (
    .a_bit       (bus.a_bit),
    .b_bit       (bus.b_bit),
    .is_msb      (is_msb),
    .signed_mode (signed_q),
    .lt_acc      (lt_acc_q),
    .eq_acc      (eq_acc_q),
    .lt_nxt      (lt_nxt),
    .eq_nxt      (eq_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      lt_acc_q    <= 1'b0;
      eq_acc_q    <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= SHIFT;
            signed_q   <= bus.signed_mode;
            cnt_q      <= '0;
            lt_acc_q   <= 1'b0;
            eq_acc_q   <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.in_valid) begin
            lt_acc_q <= lt_nxt;
            eq_acc_q <= eq_nxt;
            if (is_msb) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              res_q       <= '{lt: lt_nxt, eq: eq_nxt, gt: ~lt_nxt & ~eq_nxt};
            end else begin
              // Counter holds on the MSB beat so it never wraps.
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.lt        = res_q.lt;
  assign bus.eq        = res_q.eq;
  assign bus.gt        = res_q.gt;

`ifdef LT_INT_BITSERIAL_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q;
  logic [STAT_W-1:0] stat_lt_cnt_q;
  logic              res_hs;

  assign res_hs = (state_q == DONE) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt_q    <= '0;
      stat_lt_cnt_q <= '0;
    end else if (res_hs) begin
      if (stat_cnt_q != '1) stat_cnt_q <= stat_cnt_q + 1'b1;
      if (res_q.lt && (stat_lt_cnt_q != '1)) stat_lt_cnt_q <= stat_lt_cnt_q + 1'b1;
    end
  end

  assign stat_cnt    = stat_cnt_q;
  assign stat_lt_cnt = stat_lt_cnt_q;
`endif

endmodule

// File: tb/tb_lt_int_bitserial.sv
// Self-checking bench for lt_int_bitserial (WIDTH=8): directed table, corner sequences, random.
module tb_lt_int_bitserial;
  import pim_cmp_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_stat_cnt = 0;
  int   exp_stat_lt = 0;

  lt_int_bitserial_if bus ();

`ifdef LT_INT_BITSERIAL_STATS_EN
  logic [STAT_W-1:0] stat_cnt;
  logic [STAT_W-1:0] stat_lt_cnt;
`endif

  lt_int_bitserial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LT_INT_BITSERIAL_STATS_EN
    ,
    .stat_cnt    (stat_cnt),
    .stat_lt_cnt (stat_lt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    bit           stall;
    int           hold;
    bit           poke;
    logic [2:0]   exp_res;  // {lt, eq, gt}
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sgn);
    int ai, bi;
    ai = sgn ? int'($signed(a)) : int'(a);
    bi = sgn ? int'($signed(b)) : int'(b);
    return {ai < bi, ai == bi, ai > bi};
  endfunction

  task automatic run_compare(input vec_t v, input string tag);
    int         edges;
    int         waited;
    logic [2:0] got;
    // Stray beat in IDLE alongside start must be ignored.
    bus.start       = 1'b1;
    bus.signed_mode = v.sgn;
    bus.in_valid    = 1'b1;
    bus.a_bit       = ~v.a[0];
    bus.b_bit       = v.a[0];
    tick();
    bus.start       = 1'b0;
    bus.signed_mode = ~v.sgn;
    check({tag, " shift_ready"}, {30'd0, bus.in_ready, bus.busy}, 32'd3);
    edges = 0;
    for (int i = 0; i < int'(W); i++) begin
      bus.start    = v.poke;
      bus.in_valid = 1'b1;
      bus.a_bit    = v.a[i];
      bus.b_bit    = v.b[i];
      if (i == int'(W) - 1) check({tag, " early_valid"}, {31'd0, bus.out_valid}, 32'd0);
      tick();
      edges++;
      if (v.stall && i != int'(W) - 1) begin
        bus.in_valid = 1'b0;
        bus.a_bit    = 1'($urandom);
        bus.b_bit    = 1'($urandom);
        tick();
        edges++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check({tag, " latency"}, edges, v.stall ? 2 * W - 1 : W);
    waited = 0;
    while (!bus.out_valid && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, " out_valid_on_time"}, waited, 0);
    got = {bus.lt, bus.eq, bus.gt};
    check({tag, " result"}, {29'd0, got}, {29'd0, v.exp_res});
    for (int h = 0; h < v.hold; h++) begin
      bus.out_ready = 1'b0;
      bus.start     = v.poke;
      bus.in_valid  = 1'b1;
      bus.a_bit     = 1'($urandom);
      bus.b_bit     = 1'($urandom);
      tick();
      check({tag, " hold_stable"}, {28'd0, bus.out_valid, bus.lt, bus.eq, bus.gt},
            {28'd0, 1'b1, v.exp_res});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = v.poke;
    tick();
    if (got == v.exp_res) begin
      exp_stat_cnt++;
      if (v.exp_res[2]) exp_stat_lt++;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, " cleared"}, {27'd0, bus.out_valid, bus.lt, bus.eq, bus.gt, bus.busy}, 32'd0);
    tick();
    check({tag, " stays_idle"}, {30'd0, bus.busy, bus.in_ready}, 32'd0);
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    tbl[0] = '{a: 8'hFE, b: 8'h01, sgn: 1'b1, stall: 0, hold: 0, poke: 0, exp_res: 3'b100};
    tbl[1] = '{a: 8'hFE, b: 8'h01, sgn: 1'b0, stall: 0, hold: 0, poke: 0, exp_res: 3'b001};
    tbl[2] = '{a: 8'h5A, b: 8'h5A, sgn: 1'b1, stall: 0, hold: 5, poke: 1, exp_res: 3'b010};
    tbl[3] = '{a: 8'h80, b: 8'h7F, sgn: 1'b1, stall: 1, hold: 1, poke: 1, exp_res: 3'b100};
    tbl[4] = '{a: 8'h80, b: 8'h7F, sgn: 1'b0, stall: 1, hold: 0, poke: 0, exp_res: 3'b001};

    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.in_valid = 1'b0;
    bus.a_bit = 1'b0; bus.b_bit = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_outputs", {26'd0, bus.in_ready, bus.out_valid, bus.lt, bus.eq, bus.gt, bus.busy},
          32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_compare(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-compare discards the partial result.
    bus.start = 1'b1; bus.signed_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a_bit    = (i == 0);
      bus.b_bit    = (i == 1);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_stat_cnt = 0;
    exp_stat_lt  = 0;
    check("midreset_outputs",
          {26'd0, bus.in_ready, bus.out_valid, bus.lt, bus.eq, bus.gt, bus.busy}, 32'd0);
    tick();
    check("midreset_idle", {31'd0, bus.busy}, 32'd0);
    v = '{a: 8'h03, b: 8'h03, sgn: 1'b0, stall: 0, hold: 2, poke: 1, exp_res: 3'b010};
    run_compare(v, "post_reset");

    for (int r = 0; r < 24; r++) begin
      v.a     = W'($urandom);
      v.b     = (r % 4 == 0) ? v.a : W'($urandom);
      v.sgn   = 1'($urandom);
      v.stall = 1'($urandom);
      v.hold  = int'($urandom_range(0, 3));
      v.poke  = 1'($urandom);
      v.exp_res = model(v.a, v.b, v.sgn);
      run_compare(v, $sformatf("rnd%0d", r));
    end

`ifdef LT_INT_BITSERIAL_STATS_EN
    check("stat_cnt", {16'd0, stat_cnt}, exp_stat_cnt);
    check("stat_lt_cnt", {16'd0, stat_lt_cnt}, exp_stat_lt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
